// File: rtl/i2s_dac_tx.sv
// rtl/i2s_dac_tx.sv - Stream-to-I2S (Philips) master transmitter with one-frame buffer
//
// Purpose: accepts 24-bit left/right words over a valid/ready handshake
// (dac_last marks the right word), holds one complete stereo frame and
// serializes it as an I2S master (BCLK, LRCLK, SDATA). Reports underrun and
// framing-error status.
//
// Ports:
//   clk, rst              system clock, asynchronous active-high reset
//   dac_data/valid/last   sample stream in; dac_ready out
//   i2s_bclk/lrclk/sdata  I2S master outputs
//   cmd_clear_status      single-cycle pulse clearing all status outputs
//   sr_underrun           sticky underrun flag
//   sr_underrun_count     saturating underrun count
//   sr_framing_error      sticky out-of-order dac_last flag
//
// Build option: I2S_DAC_TX_UNDERRUN_REPEAT_EN - when defined, an underrun
// retransmits the previous frame; otherwise silence is sent.
module i2s_dac_tx #(
  parameter int AUDIO_WIDTH_P = 24,
  parameter int SLOT_WIDTH_P  = 32,
  parameter int BCLK_DIV_P    = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [AUDIO_WIDTH_P-1:0] dac_data,
  input  logic                     dac_valid,
  output logic                     dac_ready,
  input  logic                     dac_last,
  output logic                     i2s_bclk,
  output logic                     i2s_lrclk,
  output logic                     i2s_sdata,
  input  logic                     cmd_clear_status,
  output logic                     sr_underrun,
  output logic [15:0]              sr_underrun_count,
  output logic                     sr_framing_error
);

  localparam int W     = AUDIO_WIDTH_P;
  localparam int S     = SLOT_WIDTH_P;
  localparam int N_W   = $clog2(2 * S);
  localparam int DIV_W = (BCLK_DIV_P > 1) ? $clog2(BCLK_DIV_P) : 1;

  localparam logic [N_W-1:0]   N_LAST   = N_W'(2 * S - 1);
  localparam logic [N_W-1:0]   N_S      = N_W'(S);
  localparam logic [N_W-1:0]   N_ONE    = N_W'(1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV_P - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  typedef enum logic [1:0] {
    RX_LEFT  = 2'd0,
    RX_RIGHT = 2'd1,
    RX_FULL  = 2'd2
  } rx_state_e;

  rx_state_e        rx_q;
  logic [DIV_W-1:0] div_cnt_q;
  logic             bclk_q;
  logic [N_W-1:0]   n_q;
  logic             lrclk_q;
  logic             sdata_q;
  logic [W-1:0]     buf_l_q, buf_r_q;
  logic [W-1:0]     act_l_q, act_r_q;
  logic             underrun_q;
  logic [15:0]      underrun_cnt_q;
  logic             framing_q;

  logic             div_wrap;
  logic             bclk_fall;
  logic [N_W-1:0]   n_next;
  logic             load_evt;
  logic             underrun_evt;
  logic [N_W-1:0]   k;
  logic [N_W-1:0]   slot_k;
  logic [W-1:0]     sel_word;
  logic             sdata_bit;
  logic [W-1:0]     act_l_d, act_r_d;
  logic             hs;
  logic             fe_set;

  assign dac_ready         = (rx_q != RX_FULL);
  assign i2s_bclk          = bclk_q;
  assign i2s_lrclk         = lrclk_q;
  assign i2s_sdata         = sdata_q;
  assign sr_underrun       = underrun_q;
  assign sr_underrun_count = underrun_cnt_q;
  assign sr_framing_error  = framing_q;

  always_comb begin
    div_wrap     = (div_cnt_q == DIV_LAST);
    bclk_fall    = div_wrap && bclk_q;
    n_next       = (n_q == N_LAST) ? '0 : n_q + N_ONE;
    load_evt     = bclk_fall && (n_next == N_ONE);
    underrun_evt = load_evt && (rx_q != RX_FULL);
    hs           = dac_valid && dac_ready;
    fe_set       = hs && (((rx_q == RX_LEFT) && dac_last) ||
                          ((rx_q == RX_RIGHT) && !dac_last));

    act_l_d = act_l_q;
    act_r_d = act_r_q;
    if (load_evt) begin
      if (rx_q == RX_FULL) begin
        act_l_d = buf_l_q;
        act_r_d = buf_r_q;
      end else begin
`ifdef I2S_DAC_TX_UNDERRUN_REPEAT_EN
        act_l_d = act_l_q;
        act_r_d = act_r_q;
`else
        act_l_d = '0;
        act_r_d = '0;
`endif
      end
    end

    // Bit index lags n by one BCLK, giving the I2S MSB delay after each
    // LRCLK edge. The bit is taken from the frame being loaded this cycle so
    // the left MSB of a fresh frame goes out on the load edge itself.
    k        = (n_next == '0) ? N_LAST : n_next - N_ONE;
    sel_word = (k < N_S) ? act_l_d : act_r_d;
    slot_k   = (k < N_S) ? k : k - N_S;
    sdata_bit = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (slot_k == N_W'(i)) begin
        sdata_bit = sel_word[W-1-i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_q           <= RX_LEFT;
      div_cnt_q      <= '0;
      bclk_q         <= 1'b0;
      n_q            <= N_LAST;
      lrclk_q        <= 1'b1;
      sdata_q        <= 1'b0;
      buf_l_q        <= '0;
      buf_r_q        <= '0;
      act_l_q        <= '0;
      act_r_q        <= '0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= '0;
      framing_q      <= 1'b0;
    end else begin
      div_cnt_q <= div_wrap ? '0 : div_cnt_q + DIV_ONE;
      if (div_wrap) begin
        bclk_q <= ~bclk_q;
      end
      if (bclk_fall) begin
        n_q     <= n_next;
        lrclk_q <= (n_next >= N_S);
        sdata_q <= sdata_bit;
      end
      act_l_q <= act_l_d;
      act_r_q <= act_r_d;

      case (rx_q)
        RX_LEFT: begin
          if (hs && !dac_last) begin
            buf_l_q <= dac_data;
            rx_q    <= RX_RIGHT;
          end
        end
        RX_RIGHT: begin
          if (hs) begin
            if (dac_last) begin
              buf_r_q <= dac_data;
              rx_q    <= RX_FULL;
            end else begin
              buf_l_q <= dac_data;
            end
          end
        end
        RX_FULL: begin
          if (load_evt) begin
            rx_q <= RX_LEFT;
          end
        end
        default: rx_q <= RX_LEFT;
      endcase

      // Clear wins over any set arriving in the same cycle.
      if (cmd_clear_status) begin
        underrun_q     <= 1'b0;
        underrun_cnt_q <= '0;
        framing_q      <= 1'b0;
      end else begin
        if (underrun_evt) begin
          underrun_q <= 1'b1;
          if (underrun_cnt_q != 16'hFFFF) begin
            underrun_cnt_q <= underrun_cnt_q + 16'd1;
          end
        end
        if (fe_set) begin
          framing_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// tb/tb_i2s_dac_tx.sv - directed self-checking bench for i2s_dac_tx
module tb_i2s_dac_tx;

  localparam int W   = 24;
  localparam int S   = 32;
  localparam int DIV = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  dac_data = '0;
  logic          dac_valid = 1'b0;
  logic          dac_ready;
  logic          dac_last = 1'b0;
  logic          i2s_bclk;
  logic          i2s_lrclk;
  logic          i2s_sdata;
  logic          cmd_clear_status = 1'b0;
  logic          sr_underrun;
  logic [15:0]   sr_underrun_count;
  logic          sr_framing_error;

  int tests_run = 0;
  int tests_failed = 0;

  logic [63:0] frames[$];

  always #5 clk = ~clk;

  i2s_dac_tx #(
    .AUDIO_WIDTH_P(W),
    .SLOT_WIDTH_P (S),
    .BCLK_DIV_P   (DIV)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .dac_data         (dac_data),
    .dac_valid        (dac_valid),
    .dac_ready        (dac_ready),
    .dac_last         (dac_last),
    .i2s_bclk         (i2s_bclk),
    .i2s_lrclk        (i2s_lrclk),
    .i2s_sdata        (i2s_sdata),
    .cmd_clear_status (cmd_clear_status),
    .sr_underrun      (sr_underrun),
    .sr_underrun_count(sr_underrun_count),
    .sr_framing_error (sr_framing_error)
  );

  // Receiver: from each LRCLK fall, capture 64 bits on BCLK rising edges.
  // Bit 63 of the record is the delay bit, then left slot, then right slot.
  initial begin : monitor
    int          bitcnt;
    logic        prev_bclk;
    logic        prev_lr;
    logic [63:0] raw;
    bitcnt = -1;
    prev_bclk = 1'b0;
    prev_lr = 1'b1;
    raw = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bitcnt = -1;
        prev_bclk = 1'b0;
        prev_lr = 1'b1;
      end else begin
        if (prev_lr && !i2s_lrclk) begin
          bitcnt = 0;
          raw = '0;
        end
        if (!prev_bclk && i2s_bclk && bitcnt >= 0) begin
          raw[63-bitcnt] = i2s_sdata;
          bitcnt++;
          if (bitcnt == 64) begin
            frames.push_back(raw);
            bitcnt = -1;
          end
        end
        prev_bclk = i2s_bclk;
        prev_lr = i2s_lrclk;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [63:0] exp_frame(input logic [W-1:0] l, input logic [W-1:0] r);
    return {1'b0, l, 8'h00, r, 7'h00};
  endfunction

  function automatic logic [63:0] frame_at(input int i);
    if (frames.size() > i) return frames[i];
    return 'x;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    dac_valid = 1'b0;
    dac_last = 1'b0;
    dac_data = '0;
    cmd_clear_status = 1'b0;
    repeat (3) step();
    frames.delete();
    rst = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] d, input logic l, output int waited);
    dac_data = d;
    dac_last = l;
    dac_valid = 1'b1;
    waited = 0;
    while (!dac_ready && waited < 1000) begin
      step();
      waited++;
    end
    if (!dac_ready) begin
      tests_run++;
      tests_failed++;
      $display("FAIL send_timeout: dac_ready=%b required 1", dac_ready);
    end
    step();
  endtask

  task automatic wait_frames(input int n);
    int c;
    c = 0;
    while (frames.size() < n && c < 2000) begin
      step();
      c++;
    end
    tests_run++;
    if (frames.size() < n) begin
      tests_failed++;
      $display("FAIL frame_timeout: captured %0d frames required %0d", frames.size(), n);
    end
  endtask

  task automatic test_reset();
    int w;
    logic [7:0] exp_b;
    logic [7:0] exp_lr;
    logic [7:0] got_b;
    logic [7:0] got_lr;
    do_reset();
    send_word(24'h111111, 1'b1, w);
    send_word(24'h800001, 1'b0, w);
    send_word(24'h7FFFFE, 1'b1, w);
    dac_valid = 1'b0;
    repeat (3) step();
    tests_run++;
    if ({i2s_bclk, i2s_lrclk, dac_ready, sr_framing_error} !== 4'b1001) begin
      tests_failed++;
      $display("FAIL pre_reset_state: bclk/lr/ready/fe=%b required 1001",
               {i2s_bclk, i2s_lrclk, dac_ready, sr_framing_error});
    end
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({i2s_bclk, i2s_lrclk, i2s_sdata, dac_ready} !== 4'b0101) begin
      tests_failed++;
      $display("FAIL async_reset_io: bclk/lr/sdata/ready=%b required 0101",
               {i2s_bclk, i2s_lrclk, i2s_sdata, dac_ready});
    end
    tests_run++;
    if ({sr_underrun, sr_underrun_count, sr_framing_error} !== 18'h0) begin
      tests_failed++;
      $display("FAIL async_reset_status: got %h required 0",
               {sr_underrun, sr_underrun_count, sr_framing_error});
    end
    step();
    step();
    frames.delete();
    rst = 1'b0;
    exp_b  = 8'b0110_0110;
    exp_lr = 8'b1110_0000;
    for (int i = 0; i < 8; i++) begin
      step();
      got_b[7-i]  = i2s_bclk;
      got_lr[7-i] = i2s_lrclk;
    end
    tests_run++;
    if (got_b !== exp_b) begin
      tests_failed++;
      $display("FAIL bclk_after_release: got %b required %b", got_b, exp_b);
    end
    tests_run++;
    if (got_lr !== exp_lr) begin
      tests_failed++;
      $display("FAIL lrclk_after_release: got %b required %b", got_lr, exp_lr);
    end
    tests_run++;
    if ({sr_underrun, sr_underrun_count} !== {1'b1, 16'd1}) begin
      tests_failed++;
      $display("FAIL reset_discards_frame: underrun/count=%b/%0d required 1/1",
               sr_underrun, sr_underrun_count);
    end
    wait_frames(1);
    tests_run++;
    if (frame_at(0) !== 64'h0) begin
      tests_failed++;
      $display("FAIL silence_after_reset: got %h required 0", frame_at(0));
    end
  endtask

  task automatic test_single_frame();
    int w;
    do_reset();
    send_word(24'h800001, 1'b0, w);
    send_word(24'h7FFFFE, 1'b1, w);
    dac_valid = 1'b0;
    tests_run++;
    if (dac_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL ready_full: got %b required 0", dac_ready);
    end
    wait_frames(1);
    tests_run++;
    if (frame_at(0) !== exp_frame(24'h800001, 24'h7FFFFE)) begin
      tests_failed++;
      $display("FAIL single_frame: got %h required %h", frame_at(0),
               exp_frame(24'h800001, 24'h7FFFFE));
    end
    tests_run++;
    if (sr_underrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_no_underrun: got %b required 0", sr_underrun);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    do_reset();
    send_word(24'hA5A5A5, 1'b0, w);
    send_word(24'h5A5A5A, 1'b1, w);
    tests_run++;
    if (dac_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_ready_f1: got %b required 0", dac_ready);
    end
    send_word(24'h000001, 1'b0, w);
    tests_run++;
    if (w != 6) begin
      tests_failed++;
      $display("FAIL bp_wait_f2: got %0d cycles required 6", w);
    end
    send_word(24'h800000, 1'b1, w);
    tests_run++;
    if (dac_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_ready_f2: got %b required 0", dac_ready);
    end
    send_word(24'hFFFFFF, 1'b0, w);
    tests_run++;
    if (w != 254) begin
      tests_failed++;
      $display("FAIL bp_wait_f3: got %0d cycles required 254", w);
    end
    send_word(24'h000000, 1'b1, w);
    dac_valid = 1'b0;
    wait_frames(3);
    tests_run++;
    if (frame_at(0) !== exp_frame(24'hA5A5A5, 24'h5A5A5A)) begin
      tests_failed++;
      $display("FAIL bp_frame0: got %h required %h", frame_at(0), exp_frame(24'hA5A5A5, 24'h5A5A5A));
    end
    tests_run++;
    if (frame_at(1) !== exp_frame(24'h000001, 24'h800000)) begin
      tests_failed++;
      $display("FAIL bp_frame1: got %h required %h", frame_at(1), exp_frame(24'h000001, 24'h800000));
    end
    tests_run++;
    if (frame_at(2) !== exp_frame(24'hFFFFFF, 24'h000000)) begin
      tests_failed++;
      $display("FAIL bp_frame2: got %h required %h", frame_at(2), exp_frame(24'hFFFFFF, 24'h000000));
    end
    tests_run++;
    if (sr_underrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_no_underrun: got %b required 0", sr_underrun);
    end
  endtask

  task automatic test_underrun();
    int w;
    logic [63:0] exp_rep;
    do_reset();
    send_word(24'h123456, 1'b0, w);
    send_word(24'hABCDEF, 1'b1, w);
    dac_valid = 1'b0;
`ifdef I2S_DAC_TX_UNDERRUN_REPEAT_EN
    exp_rep = exp_frame(24'h123456, 24'hABCDEF);
`else
    exp_rep = 64'h0;
`endif
    wait_frames(3);
    tests_run++;
    if (frame_at(0) !== exp_frame(24'h123456, 24'hABCDEF)) begin
      tests_failed++;
      $display("FAIL ur_frame0: got %h required %h", frame_at(0), exp_frame(24'h123456, 24'hABCDEF));
    end
    tests_run++;
    if (frame_at(1) !== exp_rep || frame_at(2) !== exp_rep) begin
      tests_failed++;
      $display("FAIL ur_frames12: got %h %h required %h", frame_at(1), frame_at(2), exp_rep);
    end
    tests_run++;
    if ({sr_underrun, sr_underrun_count} !== {1'b1, 16'd2}) begin
      tests_failed++;
      $display("FAIL ur_count2: underrun/count=%b/%0d required 1/2", sr_underrun, sr_underrun_count);
    end
    wait_frames(4);
    tests_run++;
    if (sr_underrun_count !== 16'd3) begin
      tests_failed++;
      $display("FAIL ur_count3: got %0d required 3", sr_underrun_count);
    end
  endtask

  task automatic test_framing();
    int w;
    do_reset();
    send_word(24'h111111, 1'b1, w);
    tests_run++;
    if ({sr_framing_error, dac_ready} !== 2'b11) begin
      tests_failed++;
      $display("FAIL fe_set: fe/ready=%b required 11", {sr_framing_error, dac_ready});
    end
    send_word(24'h0F0F0F, 1'b0, w);
    send_word(24'hF0F0F0, 1'b1, w);
    dac_valid = 1'b0;
    wait_frames(1);
    tests_run++;
    if (frame_at(0) !== exp_frame(24'h0F0F0F, 24'hF0F0F0)) begin
      tests_failed++;
      $display("FAIL fe_frame: got %h required %h", frame_at(0), exp_frame(24'h0F0F0F, 24'hF0F0F0));
    end
    tests_run++;
    if ({sr_underrun, sr_framing_error} !== 2'b01) begin
      tests_failed++;
      $display("FAIL fe_status_hold: underrun/fe=%b required 01", {sr_underrun, sr_framing_error});
    end
  endtask

  task automatic test_clear_race();
    do_reset();
    repeat (7) step();
    cmd_clear_status = 1'b1;
    dac_data = 24'h222222;
    dac_last = 1'b1;
    dac_valid = 1'b1;
    step();
    cmd_clear_status = 1'b0;
    dac_valid = 1'b0;
    dac_last = 1'b0;
    tests_run++;
    if ({sr_underrun, sr_underrun_count, sr_framing_error} !== 18'h0) begin
      tests_failed++;
      $display("FAIL clear_race: got %h required 0",
               {sr_underrun, sr_underrun_count, sr_framing_error});
    end
    repeat (255) step();
    tests_run++;
    if (sr_underrun_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL clear_before_next: got %0d required 0", sr_underrun_count);
    end
    step();
    tests_run++;
    if ({sr_underrun, sr_underrun_count} !== {1'b1, 16'd1}) begin
      tests_failed++;
      $display("FAIL clear_next_underrun: underrun/count=%b/%0d required 1/1",
               sr_underrun, sr_underrun_count);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_underrun();
    test_framing();
    test_clear_race();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
